// File: rtl/scan_encoder_pkg.sv
// Shared types for the scan encoder: emission order and FSM state.
package scan_encoder_pkg;

  typedef enum logic [1:0] {MODE_MSB, MODE_LSB, MODE_RR, MODE_RSV} mode_t;

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

endpackage

// File: rtl/rotate_pick.sv
// Lowest-set-bit finder on a vector rotated right by 'rotate'; purely combinational.
// 'found' is the position in the rotated vector; callers add 'rotate' back (mod NUM_ENTRY).
module rotate_pick #(
  parameter int NUM_ENTRY = 8,
  parameter int WIDTH_ENC = $clog2(NUM_ENTRY)
) (
  input  logic [NUM_ENTRY-1:0] vector,
  input  logic [WIDTH_ENC-1:0] rotate,
  output logic [WIDTH_ENC-1:0] found
);

  logic [2*NUM_ENTRY-1:0] doubled;
  logic [NUM_ENTRY-1:0]   rotated;

  // rotated[i] = vector[(i + rotate) mod NUM_ENTRY], valid for any rotate < NUM_ENTRY
  assign doubled = {vector, vector} >> rotate;
  assign rotated = doubled[NUM_ENTRY-1:0];

  always_comb begin
    found = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (rotated[i]) found = WIDTH_ENC'(i);
    end
  end

endmodule

// File: rtl/scan_encoder.sv
// Serialises a multi-hot request vector into one binary index per beat (MSB, LSB or round-robin order).
// First beat one cycle after accept; I_Ready low freezes all state; next vector may load on the last beat.
module scan_encoder
  import scan_encoder_pkg::*;
#(
  parameter int NUM_ENTRY = 8,
  parameter int WIDTH_ENC = $clog2(NUM_ENTRY),
  parameter int WIDTH_CNT = $clog2(NUM_ENTRY + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 I_Valid,
  input  logic [NUM_ENTRY-1:0] I_Data,
  input  logic [1:0]           I_Mode,
  output logic                 O_Ready,
  output logic                 O_Valid,
  output logic [WIDTH_ENC-1:0] O_Enc,
  output logic                 O_Last,
  output logic [WIDTH_CNT-1:0] O_Remain,
  input  logic                 I_Ready
);

  localparam logic [WIDTH_ENC-1:0] LAST_IDX  = WIDTH_ENC'(NUM_ENTRY - 1);
  localparam logic [WIDTH_ENC:0]   ENTRY_EXT = (WIDTH_ENC + 1)'(NUM_ENTRY);

  function automatic logic [WIDTH_CNT-1:0] popcount(input logic [NUM_ENTRY-1:0] v);
    logic [WIDTH_CNT-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_ENTRY; i++) cnt = cnt + WIDTH_CNT'(v[i]);
    return cnt;
  endfunction

  state_t               state;
  mode_t                mode;
  logic [NUM_ENTRY-1:0] pending;
  logic [WIDTH_ENC-1:0] ptr;

  logic [NUM_ENTRY-1:0] reversed;
  logic [WIDTH_ENC-1:0] fwd_rotate;
  logic [WIDTH_ENC-1:0] fwd_found;
  logic [WIDTH_ENC-1:0] rev_found;
  logic [WIDTH_ENC:0]   rr_sum;
  logic [WIDTH_ENC-1:0] pick;
  logic                 beat;
  logic                 accept;

  always_comb begin
    reversed = '0;
    for (int i = 0; i < NUM_ENTRY; i++) reversed[i] = pending[NUM_ENTRY-1-i];
  end

  assign fwd_rotate = (mode == MODE_RR) ? ptr : '0;

  rotate_pick #(
    .NUM_ENTRY (NUM_ENTRY),
    .WIDTH_ENC (WIDTH_ENC)
  ) u_pick_fwd (
    .vector (pending),
    .rotate (fwd_rotate),
    .found  (fwd_found)
  );

  rotate_pick #(
    .NUM_ENTRY (NUM_ENTRY),
    .WIDTH_ENC (WIDTH_ENC)
  ) u_pick_rev (
    .vector (reversed),
    .rotate ('0),
    .found  (rev_found)
  );

  // Reserved mode falls into the default arm and behaves as MSB-first.
  always_comb begin
    rr_sum = {1'b0, fwd_found} + {1'b0, ptr};
    if (rr_sum >= ENTRY_EXT) rr_sum = rr_sum - ENTRY_EXT;
    case (mode)
      MODE_LSB: pick = fwd_found;
      MODE_RR:  pick = rr_sum[WIDTH_ENC-1:0];
      default:  pick = LAST_IDX - rev_found;
    endcase
  end

  assign O_Valid  = (state == ST_SCAN);
  assign O_Enc    = O_Valid ? pick : '0;
  assign O_Remain = O_Valid ? popcount(pending) : '0;
  assign O_Last   = O_Valid && (O_Remain == WIDTH_CNT'(1));
  assign O_Ready  = !O_Valid || (I_Ready && O_Last);

  assign beat   = O_Valid && I_Ready;
  assign accept = I_Valid && O_Ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      mode    <= MODE_MSB;
      pending <= '0;
      ptr     <= '0;
    end else begin
      if (beat) begin
        pending[O_Enc] <= 1'b0;
        if (mode == MODE_RR) ptr <= (O_Enc == LAST_IDX) ? '0 : O_Enc + WIDTH_ENC'(1);
        if (O_Last) state <= ST_IDLE;
      end
      // A load on the final beat overrides the clear above; the pointer advance still applies.
      if (accept) begin
        pending <= I_Data;
        mode    <= mode_t'(I_Mode);
        state   <= (I_Data != '0) ? ST_SCAN : ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_scan_encoder.sv
// Directed bench for scan_encoder: an 8-entry instance for most scenarios and a 5-entry one for wraparound.
module tb_scan_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       v8 = 1'b0;
  logic [7:0] d8 = '0;
  logic [1:0] m8 = '0;
  logic       r8 = 1'b1;
  logic       o_ready8, o_valid8, o_last8;
  logic [2:0] o_enc8;
  logic [3:0] o_remain8;

  logic       v5 = 1'b0;
  logic [4:0] d5 = '0;
  logic [1:0] m5 = '0;
  logic       r5 = 1'b1;
  logic       o_ready5, o_valid5, o_last5;
  logic [2:0] o_enc5;
  logic [2:0] o_remain5;

  int total = 0;
  int bad = 0;

  scan_encoder #(.NUM_ENTRY(8)) dut8 (
    .clock    (clk),
    .reset    (reset),
    .I_Valid  (v8),
    .I_Data   (d8),
    .I_Mode   (m8),
    .O_Ready  (o_ready8),
    .O_Valid  (o_valid8),
    .O_Enc    (o_enc8),
    .O_Last   (o_last8),
    .O_Remain (o_remain8),
    .I_Ready  (r8)
  );

  scan_encoder #(.NUM_ENTRY(5)) dut5 (
    .clock    (clk),
    .reset    (reset),
    .I_Valid  (v5),
    .I_Data   (d5),
    .I_Mode   (m5),
    .O_Ready  (o_ready5),
    .O_Valid  (o_valid5),
    .O_Enc    (o_enc5),
    .O_Last   (o_last5),
    .O_Remain (o_remain5),
    .I_Ready  (r5)
  );

  initial forever #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic beat8(input string tag, input int v, input int e, input int rem, input int l);
    chk({tag, ".valid"},  32'(o_valid8),  v);
    chk({tag, ".enc"},    32'(o_enc8),    e);
    chk({tag, ".remain"}, 32'(o_remain8), rem);
    chk({tag, ".last"},   32'(o_last8),   l);
  endtask

  task automatic beat5(input string tag, input int v, input int e, input int rem, input int l);
    chk({tag, ".valid"},  32'(o_valid5),  v);
    chk({tag, ".enc"},    32'(o_enc5),    e);
    chk({tag, ".remain"}, 32'(o_remain5), rem);
    chk({tag, ".last"},   32'(o_last5),   l);
  endtask

  initial begin
    reset = 1'b1;
    cyc();
    cyc();
    beat8("rst8", 0, 0, 0, 0);
    chk("rst8.ready", 32'(o_ready8), 1);
    beat5("rst5", 0, 0, 0, 0);
    chk("rst5.ready", 32'(o_ready5), 1);
    reset = 1'b0;

    // MSB-first
    v8 = 1'b1; d8 = 8'b1010_0100; m8 = 2'd0;
    #1 chk("msb.ready_idle", 32'(o_ready8), 1);
    cyc(); v8 = 1'b0;
    beat8("msb.b0", 1, 7, 3, 0);
    cyc(); beat8("msb.b1", 1, 5, 2, 0);
    cyc(); beat8("msb.b2", 1, 2, 1, 1);
    cyc(); beat8("msb.idle", 0, 0, 0, 0);

    // LSB-first, then back-to-back vector on the last beat
    v8 = 1'b1; d8 = 8'b1010_0100; m8 = 2'd1;
    cyc(); v8 = 1'b0;
    beat8("lsb.b0", 1, 2, 3, 0);
    cyc(); beat8("lsb.b1", 1, 5, 2, 0);
    cyc(); beat8("lsb.b2", 1, 7, 1, 1);
    v8 = 1'b1; d8 = 8'b0000_0001;
    #1 chk("b2b.ready_last", 32'(o_ready8), 1);
    cyc(); v8 = 1'b0;
    beat8("b2b.b0", 1, 0, 1, 1);
    cyc(); beat8("b2b.idle", 0, 0, 0, 0);

    // Round-robin after reset
    reset = 1'b1;
    cyc(); reset = 1'b0;
    beat8("rr.rst", 0, 0, 0, 0);
    v8 = 1'b1; d8 = 8'b1000_0011; m8 = 2'd2;
    cyc(); v8 = 1'b0;
    beat8("rr1.b0", 1, 0, 3, 0);
    cyc(); beat8("rr1.b1", 1, 1, 2, 0);
    cyc(); beat8("rr1.b2", 1, 7, 1, 1);
    cyc(); beat8("rr1.idle", 0, 0, 0, 0);
    v8 = 1'b1; d8 = 8'b0000_0011;
    cyc(); v8 = 1'b0;
    beat8("rr2.b0", 1, 0, 2, 0);
    cyc(); beat8("rr2.b1", 1, 1, 1, 1);
    cyc();
    v8 = 1'b1; d8 = 8'b0000_0101;
    cyc(); v8 = 1'b0;
    beat8("rr3.b0", 1, 2, 2, 0);
    cyc(); beat8("rr3.b1", 1, 0, 1, 1);
    cyc(); beat8("rr3.idle", 0, 0, 0, 0);

    // Five-entry round-robin wrap: bring Ptr to 2, then 5'b10001 gives 4 then 0
    v5 = 1'b1; d5 = 5'b00010; m5 = 2'd2;
    cyc(); v5 = 1'b0;
    beat5("n5a.b0", 1, 1, 1, 1);
    cyc(); beat5("n5a.idle", 0, 0, 0, 0);
    v5 = 1'b1; d5 = 5'b10001;
    cyc(); v5 = 1'b0;
    beat5("n5b.b0", 1, 4, 2, 0);
    cyc(); beat5("n5b.b1", 1, 0, 1, 1);
    cyc(); beat5("n5b.idle", 0, 0, 0, 0);

    // Stall mid-vector
    v8 = 1'b1; d8 = 8'b0110_1001; m8 = 2'd1;
    cyc(); v8 = 1'b0;
    beat8("stl.b0", 1, 0, 4, 0);
    cyc(); beat8("stl.b1", 1, 3, 3, 0);
    r8 = 1'b0;
    #1 chk("stl.ready_low", 32'(o_ready8), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      beat8($sformatf("stl.hold%0d", i), 1, 3, 3, 0);
      chk($sformatf("stl.hold%0d.ready", i), 32'(o_ready8), 0);
    end
    r8 = 1'b1;
    cyc(); beat8("stl.b2", 1, 5, 2, 0);
    cyc(); beat8("stl.b3", 1, 6, 1, 1);
    cyc(); beat8("stl.idle", 0, 0, 0, 0);

    // Zero vector
    v8 = 1'b1; d8 = 8'h00; m8 = 2'd0;
    #1 chk("zero.ready_pre", 32'(o_ready8), 1);
    cyc(); v8 = 1'b0;
    beat8("zero.after", 0, 0, 0, 0);
    chk("zero.ready_post", 32'(o_ready8), 1);
    cyc(); beat8("zero.after2", 0, 0, 0, 0);

    // Reserved mode behaves as MSB-first
    v8 = 1'b1; d8 = 8'b0001_0010; m8 = 2'd3;
    cyc(); v8 = 1'b0;
    beat8("rsv.b0", 1, 4, 2, 0);
    cyc(); beat8("rsv.b1", 1, 1, 1, 1);
    cyc(); beat8("rsv.idle", 0, 0, 0, 0);

    // Reset on the second beat; Ptr is 1 here, so F0 starts at 4
    v8 = 1'b1; d8 = 8'b1111_0000; m8 = 2'd2;
    cyc(); v8 = 1'b0;
    beat8("mrst.b0", 1, 4, 4, 0);
    cyc(); beat8("mrst.b1", 1, 5, 3, 0);
    reset = 1'b1;
    cyc(); reset = 1'b0;
    beat8("mrst.rst", 0, 0, 0, 0);
    chk("mrst.ready", 32'(o_ready8), 1);
    // With Ptr back at 0 the order is 0 then 7
    v8 = 1'b1; d8 = 8'b1000_0001; m8 = 2'd2;
    cyc(); v8 = 1'b0;
    beat8("fresh.b0", 1, 0, 2, 0);
    cyc(); beat8("fresh.b1", 1, 7, 1, 1);
    cyc(); beat8("fresh.idle", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
